// File: rtl/ahb_lite_master.sv
// Pipelined AHB-Lite initiator fed by a valid/ready command stream.
// Address and data phases overlap; wait states and two-cycle ERROR handled.
module ahb_lite_master #(
    parameter int CNT_W = 16
) (
    input  logic             Hclk,
    input  logic             Hresetn,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [31:0]      cmd_addr,
    input  logic [31:0]      cmd_wdata,

    output logic             rsp_valid,
    output logic             rsp_write,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_err,

    output logic [1:0]       Htrans,
    output logic [31:0]      Haddr,
    output logic             Hwrite,
    output logic [31:0]      Hwdata,
    output logic             Hreadyin,
    input  logic             Hreadyout,
    input  logic             Hresp,
    input  logic [31:0]      Hrdata,

    output logic [CNT_W-1:0] xfer_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic {
        S_OKAY,
        S_ERR_HOLD
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    state_t r_state;
    state_t w_state_nxt;

    // Address stage
    logic        r_a_valid;
    logic        r_a_write;
    logic [31:0] r_a_addr;
    logic [31:0] r_a_wdata;

    // Data stage
    logic        r_d_valid;
    logic        r_d_write;
    logic [31:0] r_d_wdata;

    logic             r_rsp_valid;
    logic             r_rsp_write;
    logic [31:0]      r_rsp_rdata;
    logic             r_rsp_err;
    logic [CNT_W-1:0] r_xfer_cnt;
    logic [CNT_W-1:0] r_err_cnt;

    logic w_adv;
    logic w_done;
    logic w_flush_d;
    logic w_drive_a;
    logic w_accept;

    always_ff @(posedge Hclk) begin
        if (!Hresetn) begin
            r_state <= S_OKAY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_adv       = 1'b0;
        w_flush_d   = 1'b0;
        w_drive_a   = 1'b0;
        w_done      = Hreadyout && r_d_valid;
        unique case (r_state)
            S_OKAY: begin
                w_adv     = Hreadyout;
                w_drive_a = r_a_valid;
                if (!Hreadyout && Hresp && r_d_valid) begin
                    w_state_nxt = S_ERR_HOLD;
                end
            end
            S_ERR_HOLD: begin
                // Second ERROR cycle: retire D, keep A parked for reissue.
                if (Hreadyout) begin
                    w_flush_d   = 1'b1;
                    w_state_nxt = S_OKAY;
                end
            end
        endcase
    end

    assign w_accept  = w_adv && cmd_valid;
    assign cmd_ready = Hresetn && w_adv;

    always_ff @(posedge Hclk) begin
        if (!Hresetn) begin
            r_a_valid <= 1'b0;
            r_a_write <= 1'b0;
            r_a_addr  <= '0;
            r_a_wdata <= '0;
            r_d_valid <= 1'b0;
            r_d_write <= 1'b0;
            r_d_wdata <= '0;
        end else if (w_adv) begin
            r_d_valid <= r_a_valid;
            if (r_a_valid) begin
                r_d_write <= r_a_write;
                r_d_wdata <= r_a_wdata;
            end
            if (w_accept) begin
                r_a_valid <= 1'b1;
                r_a_write <= cmd_write;
                r_a_addr  <= cmd_addr;
                r_a_wdata <= cmd_wdata;
            end else begin
                r_a_valid <= 1'b0;
            end
        end else if (w_flush_d) begin
            r_d_valid <= 1'b0;
        end
    end

    always_ff @(posedge Hclk) begin
        if (!Hresetn) begin
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= w_done;
            if (w_done) begin
                r_rsp_write <= r_d_write;
                r_rsp_rdata <= r_d_write ? 32'h0 : Hrdata;
                r_rsp_err   <= Hresp;
            end
        end
    end

    always_ff @(posedge Hclk) begin
        if (!Hresetn) begin
            r_xfer_cnt <= '0;
            r_err_cnt  <= '0;
        end else if (w_done) begin
            r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
            if (Hresp) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
        end
    end

    assign Htrans    = w_drive_a ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign Haddr     = r_a_addr;
    assign Hwrite    = r_a_write;
    assign Hwdata    = r_d_wdata;
    assign Hreadyin  = Hreadyout;

    assign rsp_valid = r_rsp_valid;
    assign rsp_write = r_rsp_write;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign xfer_cnt  = r_xfer_cnt;
    assign err_cnt   = r_err_cnt;

endmodule

// File: doc/ahb_lite_master.md
# ahb_lite_master

Pipelined AHB-Lite initiator that drives the bridge's AHB slave port (Haddr/Htrans/Hwrite/Hwdata/Hreadyin) from a simple valid/ready command stream. It replaces hand-written testbench stimulus and on-chip sequencers.
- Overlaps the address phase of transfer N+1 with the data phase of transfer N.
- Honours Hreadyout wait states.
- Handles the two-cycle ERROR response.
- Returns one response per command, in order.

## Interface
Parameters:
- CNT_W, 16, width of the transfer and error statistics counters (wrap at 2^CNT_W).

Ports:
- Hclk  in  1  sole clock; all state updates on rising edge.
- Hresetn  in  1  synchronous, active-low reset, sampled on rising Hclk.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted at the edge where cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  32  transfer address.
- cmd_wdata  in  32  write data; ignored for reads.
- rsp_valid  out  1  one-cycle pulse per completed transfer.
- rsp_write  out  1  direction of the completed transfer.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_err  out  1  completed transfer received an ERROR response.
- Htrans  out  2  00 IDLE, 10 NONSEQ; no other encodings are used.
- Haddr  out  32  address-phase address.
- Hwrite  out  1  address-phase direction.
- Hwdata  out  32  data-phase write data.
- Hreadyin  out  1  combinational copy of Hreadyout (single-slave system HREADY).
- Hreadyout  in  1  slave ready.
- Hresp  in  1  slave response, 0 OKAY, 1 ERROR.
- Hrdata  in  32  slave read data.
- xfer_cnt  out  CNT_W  completed transfers, wrapping.
- err_cnt  out  CNT_W  completed transfers with rsp_err, wrapping.

## Operation
- Two registered stages:
  - Address stage (A): valid, write, addr, wdata. Drives Htrans/Haddr/Hwrite.
  - Data stage (D): valid, write, wdata. Drives Hwdata.
- cmd_ready = Hreadyout && !err_hold. The block is combinationally dependent on Hreadyout and forced to 0 while Hresetn is low.
- At an edge with Hreadyout=1 and err_hold=0:
  - A moves to D.
  - A loads the accepted command, or becomes empty (Htrans=IDLE) if none was accepted.
- At an edge with Hreadyout=0: A and D hold. Haddr, Htrans, Hwrite and Hwdata stay stable through wait states.
- While A is empty: Htrans=00. Haddr and Hwrite hold their last values.
- D completes at an edge with Hreadyout=1 and D valid. The next cycle:
  - rsp_valid=1, rsp_write=D.write, rsp_err=Hresp.
  - rsp_rdata=Hrdata for reads, 0 for writes.
  - xfer_cnt+1; err_cnt+1 if Hresp=1.
- ERROR handling, FSM states OKAY and ERR_HOLD:
  - OKAY→ERR_HOLD at an edge with Hresp=1 && Hreadyout=0 && D valid.
  - In ERR_HOLD, Htrans is forced to 00 and the A contents are retained, not dropped.
  - ERR_HOLD→OKAY at the next edge with Hreadyout=1. That edge completes D with rsp_err=1. A is not transferred to D.
  - The retained A command is re-driven as NONSEQ the following cycle.
- Responses leave in command order; there is never more than one response per cycle.
- Counters wrap modulo 2^CNT_W without saturation.
- Reset (any cycle, including mid-transfer) has priority over all other activity.
  - Reset values: A and D cleared, FSM=OKAY, Htrans=00, Haddr=0, Hwrite=0, Hwdata=0, rsp_valid=0, rsp_write=0, rsp_rdata=0, rsp_err=0, xfer_cnt=0, err_cnt=0.
  - In-flight transfers are discarded with no response.

## Timing
- Command accepted at edge N → NONSEQ visible on Haddr/Htrans in cycle N+1.
- First edge ≥N+1 with Hreadyout=1 (edge M) → Hwdata valid from cycle M+1.
- First edge ≥M+1 with Hreadyout=1 (edge K) → rsp_valid in cycle K+1.
- Zero wait states: accept-to-rsp_valid latency is 3 edges (N, N+1, N+2 → rsp in cycle N+3).
- Throughput with zero wait states: one transfer per cycle.
- Each wait cycle adds one cycle of latency to every stage it stalls.
- ERROR costs exactly one extra IDLE address cycle.

## Test plan
- Reset held 3 cycles with random inputs → all outputs at reset values, cmd_ready=0. After release with Hreadyout=1, cmd_ready=1.
- Single write: addr 0x8000_0004, data 0xA5A5_5A5A, Hreadyout=1 → NONSEQ+addr one cycle, Hwdata=0xA5A5_5A5A next cycle, rsp_valid with rsp_err=0, xfer_cnt=1.
- Four back-to-back writes (0x8000_0004/A5A5_5A5A, 0x8000_00FF/AEAE_AEAE, 0x8000_0011/FEFE_FEFE, 0x8000_0022/DEAD_DEAD) → each Hwdata appears exactly one cycle after its address, 4 consecutive rsp_valid pulses, xfer_cnt=4.
- Read at 0x8000_0010 with Hreadyout low 3 cycles in the data phase, Hrdata=0xBEEF_CAFE → Hwdata/Haddr stable while low, rsp_rdata=0xBEEF_CAFE, one rsp only.
- Write 1 gets ERROR (Hresp=1/Hreadyout=0 then Hresp=1/Hreadyout=1) with write 2 pending in A → Htrans=IDLE in the second error cycle, write 2 re-issued NONSEQ next cycle with the same addr, rsp_err=1 then 0, err_cnt=1.
- Additional cases:
  - Hresetn low during the data phase of a read → no rsp_valid, outputs at reset values next cycle.
  - CNT_W=2 with 5 transfers → xfer_cnt reads 1.
